// File: rtl/buzzer_pkg.sv
// Shared types for the buzzer scheduler: FSM states, grant encodings and the
// state-to-grant decode used by the output register.
package buzzer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MELODY,
    ST_CLICK,
    ST_ALARM_ON,
    ST_ALARM_OFF
  } state_t;

  typedef enum logic [1:0] {
    GNT_NONE   = 2'b00,
    GNT_MELODY = 2'b01,
    GNT_CLICK  = 2'b10,
    GNT_ALARM  = 2'b11
  } grant_t;

  function automatic grant_t grant_of(state_t s);
    case (s)
      ST_MELODY:                 return GNT_MELODY;
      ST_CLICK:                  return GNT_CLICK;
      ST_ALARM_ON, ST_ALARM_OFF: return GNT_ALARM;
      default:                   return GNT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/buzzer_scheduler_if.sv
// Request/response bundle between the requesters (master) and the buzzer
// scheduler (slave) that owns the beep pin.
interface buzzer_scheduler_if;
  logic       alarm_req;
  logic       alarm_cancel;
  logic       click_req;
  logic       melody_en;
  logic       melody_wave;
  logic       beep;
  logic [1:0] grant;
  logic       busy;
  logic       alarm_done;

  modport master (
    output alarm_req, alarm_cancel, click_req, melody_en, melody_wave,
    input  beep, grant, busy, alarm_done
  );

  modport slave (
    input  alarm_req, alarm_cancel, click_req, melody_en, melody_wave,
    output beep, grant, busy, alarm_done
  );
endinterface

// File: rtl/ms_interval_timer.sv
// Millisecond interval timer: a cycle prescaler feeding a saturating ms
// counter; expired fires on the last cycle of a target-ms interval.
module ms_interval_timer #(
  parameter int TICK_DIV = 50000,
  parameter int MS_W     = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic [MS_W-1:0] target,
  output logic [MS_W-1:0] ms_count,
  output logic            expired
);
  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  logic [PRE_W-1:0] pre;
  logic             tick;

  assign tick = (pre == PRE_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre      <= '0;
      ms_count <= '0;
    end else if (clear) begin
      pre      <= '0;
      ms_count <= '0;
    end else begin
      pre <= tick ? '0 : pre + PRE_W'(1);
      if (tick && (ms_count != '1)) ms_count <= ms_count + MS_W'(1);
    end
  end

  // Interval of N ms ends on the final cycle of the Nth ms.
  assign expired = tick && (ms_count == target - MS_W'(1));

endmodule

// File: rtl/buzzer_scheduler.sv
// Owns the beep pin: fixed-priority (alarm > click > melody) preemptive
// arbitration, internal alarm cadence and click tone, registered outputs.
module buzzer_scheduler
  import buzzer_pkg::*;
#(
  parameter int TICK_DIV      = 50000,
  parameter int TONE_DIV      = 12500,
  parameter int CLICK_MS      = 20,
  parameter int ALARM_ON_MS   = 200,
  parameter int ALARM_OFF_MS  = 200,
  parameter int ALARM_REPEATS = 5
) (
  input logic               CLK,
  input logic               RSTn,
  buzzer_scheduler_if.slave bus
);
  localparam int MAX_AL = (ALARM_ON_MS > ALARM_OFF_MS) ? ALARM_ON_MS : ALARM_OFF_MS;
  localparam int MAX_MS = (CLICK_MS > MAX_AL) ? CLICK_MS : MAX_AL;
  localparam int MS_W   = $clog2(MAX_MS + 1);
  localparam int TONE_W = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;
  localparam logic [TONE_W-1:0] TONE_LAST = TONE_W'(TONE_DIV - 1);

  state_t          state, state_next, rest_state;
  logic            restart, enter, in_alarm, expired;
  logic            done_evt, done_flag, rem_load, rem_dec;
  logic [7:0]      remaining;
  logic [MS_W-1:0] target, unused_ms_count;
  logic [TONE_W-1:0] tone_cnt;
  logic            tone;
  logic            beep_q, busy_q, done_q;
  grant_t          grant_q;

  assign in_alarm   = (state == ST_ALARM_ON) || (state == ST_ALARM_OFF);
  assign rest_state = bus.melody_en ? ST_MELODY : ST_IDLE;

  // NOTE: every always_comb output gets a default first so no path leaves a
  // variable unassigned, which would infer a latch.
  always_comb begin
    state_next = state;
    restart    = 1'b0;
    done_evt   = 1'b0;
    rem_load   = 1'b0;
    rem_dec    = 1'b0;
    if (in_alarm && bus.alarm_cancel) begin
      state_next = rest_state;
    end else if (bus.alarm_req) begin
      state_next = ST_ALARM_ON;
      restart    = 1'b1;
      rem_load   = 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.click_req)      state_next = ST_CLICK;
          else if (bus.melody_en) state_next = ST_MELODY;
        end
        ST_MELODY: begin
          if (bus.click_req)       state_next = ST_CLICK;
          else if (!bus.melody_en) state_next = ST_IDLE;
        end
        ST_CLICK: begin
          if (bus.click_req) restart    = 1'b1;
          else if (expired)  state_next = rest_state;
        end
        ST_ALARM_ON: if (expired) state_next = ST_ALARM_OFF;
        ST_ALARM_OFF: begin
          if (expired) begin
            if (remaining > 8'd1) begin
              rem_dec    = 1'b1;
              state_next = ST_ALARM_ON;
            end else begin
              done_evt   = 1'b1;
              state_next = rest_state;
            end
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  assign enter = restart || (state_next != state);

  always_comb begin
    case (state)
      ST_CLICK:     target = MS_W'(CLICK_MS);
      ST_ALARM_ON:  target = MS_W'(ALARM_ON_MS);
      ST_ALARM_OFF: target = MS_W'(ALARM_OFF_MS);
      default:      target = MS_W'(MAX_MS);
    endcase
  end

  // Elapsed ms is not needed here; only the expiry strobe drives the FSM.
  ms_interval_timer #(.TICK_DIV(TICK_DIV), .MS_W(MS_W)) u_timer (
    .clk      (CLK),
    .rst      (RSTn),
    .clear    (enter),
    .target   (target),
    .ms_count (unused_ms_count),
    .expired  (expired)
  );

  always_ff @(posedge CLK or posedge RSTn) begin
    if (RSTn) state <= ST_IDLE;
    else      state <= state_next;
  end

  // Tone restarts low on every state entry so its phase is entry-aligned.
  always_ff @(posedge CLK or posedge RSTn) begin
    if (RSTn) begin
      tone_cnt <= '0;
      tone     <= 1'b0;
    end else if (enter) begin
      tone_cnt <= '0;
      tone     <= 1'b0;
    end else if (tone_cnt == TONE_LAST) begin
      tone_cnt <= '0;
      tone     <= ~tone;
    end else begin
      tone_cnt <= tone_cnt + TONE_W'(1);
    end
  end

  always_ff @(posedge CLK or posedge RSTn) begin
    if (RSTn)          remaining <= '0;
    else if (rem_load) remaining <= 8'(ALARM_REPEATS);
    else if (rem_dec)  remaining <= remaining - 8'd1;
  end

  // Outputs decode the state register, so done is staged once to line up
  // with the grant change.
  always_ff @(posedge CLK or posedge RSTn) begin
    if (RSTn) begin
      beep_q    <= 1'b0;
      grant_q   <= GNT_NONE;
      busy_q    <= 1'b0;
      done_flag <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      grant_q   <= grant_of(state);
      busy_q    <= (state != ST_IDLE);
      done_flag <= done_evt;
      done_q    <= done_flag;
      case (state)
        ST_CLICK, ST_ALARM_ON: beep_q <= tone;
        ST_MELODY:             beep_q <= bus.melody_wave;
        default:               beep_q <= 1'b0;
      endcase
    end
  end

  assign bus.beep       = beep_q;
  assign bus.grant      = grant_q;
  assign bus.busy       = busy_q;
  assign bus.alarm_done = done_q;

endmodule

// File: tb/tb_buzzer_scheduler.sv
// Self-checking bench for buzzer_scheduler: a vector table for single-cycle
// arbitration behaviour plus directed multi-cycle timing sequences.
module tb_buzzer_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  buzzer_scheduler_if bus ();

  buzzer_scheduler #(
    .TICK_DIV      (10),
    .TONE_DIV      (2),
    .CLICK_MS      (3),
    .ALARM_ON_MS   (2),
    .ALARM_OFF_MS  (2),
    .ALARM_REPEATS (2)
  ) dut (
    .CLK  (clk),
    .RSTn (rst),
    .bus  (bus)
  );

  typedef struct {
    logic       alarm_req;
    logic       alarm_cancel;
    logic       click_req;
    logic       melody_en;
    logic       melody_wave;
    logic [1:0] grant;
    logic       beep;
    logic       busy;
    logic       alarm_done;
  } vec_t;

  vec_t vecs[24];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, actual, expected);
    end
  endtask

  function automatic vec_t mk(input int a, input int c, input int k, input int m, input int w,
                              input int g, input int b, input int bs, input int d);
    vec_t v;
    v.alarm_req = 1'(a); v.alarm_cancel = 1'(c); v.click_req = 1'(k);
    v.melody_en = 1'(m); v.melody_wave = 1'(w);
    v.grant = 2'(g); v.beep = 1'(b); v.busy = 1'(bs); v.alarm_done = 1'(d);
    return v;
  endfunction

  task automatic drive(input vec_t v);
    bus.alarm_req    = v.alarm_req;
    bus.alarm_cancel = v.alarm_cancel;
    bus.click_req    = v.click_req;
    bus.melody_en    = v.melody_en;
    bus.melody_wave  = v.melody_wave;
  endtask

  // Click tone j cycles after entry: 0,0,1,1,0,0,...
  function automatic int tone_at(input int j);
    return (j / 2) % 2;
  endfunction

  // Expected beep m cycles after an alarm request edge (2 ON/OFF pairs of 20).
  function automatic int alarm_beep(input int m);
    int p;
    if (m < 1 || m > 80) return 0;
    p = (m - 1) % 40;
    if (p >= 20) return 0;
    return tone_at(p);
  endfunction

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [7:0] pat;
    logic       seen_done;

    bus.alarm_req = 0; bus.alarm_cancel = 0; bus.click_req = 0;
    bus.melody_en = 0; bus.melody_wave = 0;

    //            areq can clk men wav | grant beep busy done
    vecs[0]  = mk(0, 0, 0, 0, 0,  0, 0, 0, 0);
    vecs[1]  = mk(0, 0, 0, 1, 1,  0, 0, 0, 0);
    vecs[2]  = mk(0, 0, 0, 1, 0,  1, 0, 1, 0);
    vecs[3]  = mk(0, 0, 0, 1, 1,  1, 1, 1, 0);
    vecs[4]  = mk(0, 0, 0, 1, 1,  1, 1, 1, 0);
    vecs[5]  = mk(0, 0, 0, 1, 0,  1, 0, 1, 0);
    vecs[6]  = mk(0, 0, 0, 0, 1,  1, 1, 1, 0);
    vecs[7]  = mk(0, 0, 0, 0, 1,  0, 0, 0, 0);
    vecs[8]  = mk(0, 0, 1, 1, 1,  0, 0, 0, 0);
    vecs[9]  = mk(0, 0, 0, 1, 1,  2, 0, 1, 0);
    vecs[10] = mk(0, 0, 0, 1, 1,  2, 0, 1, 0);
    vecs[11] = mk(0, 0, 0, 1, 0,  2, 1, 1, 0);
    vecs[12] = mk(0, 0, 0, 1, 0,  2, 1, 1, 0);
    vecs[13] = mk(1, 0, 0, 1, 0,  2, 0, 1, 0);
    vecs[14] = mk(0, 1, 0, 1, 0,  3, 0, 1, 0);
    vecs[15] = mk(0, 0, 0, 1, 0,  1, 0, 1, 0);
    vecs[16] = mk(0, 0, 0, 1, 1,  1, 1, 1, 0);
    vecs[17] = mk(0, 1, 0, 0, 0,  1, 0, 1, 0);
    vecs[18] = mk(0, 0, 0, 0, 1,  0, 0, 0, 0);
    vecs[19] = mk(1, 1, 0, 0, 0,  0, 0, 0, 0);
    vecs[20] = mk(0, 0, 0, 0, 0,  3, 0, 1, 0);
    vecs[21] = mk(1, 1, 0, 0, 0,  3, 0, 1, 0);
    vecs[22] = mk(0, 0, 0, 0, 0,  0, 0, 0, 0);
    vecs[23] = mk(0, 0, 0, 0, 0,  0, 0, 0, 0);

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_beep", bus.beep, 0);
    check("rst_grant", bus.grant, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.alarm_done, 0);
    rst = 1'b0;

    // Vector table: inputs sampled at the next edge, outputs checked after it.
    for (int i = 0; i < 24; i++) begin
      drive(vecs[i]);
      @(negedge clk);
      check($sformatf("vec%0d_grant", i), bus.grant, vecs[i].grant);
      check($sformatf("vec%0d_beep", i), bus.beep, vecs[i].beep);
      check($sformatf("vec%0d_busy", i), bus.busy, vecs[i].busy);
      check($sformatf("vec%0d_done", i), bus.alarm_done, vecs[i].alarm_done);
    end

    // Click in IDLE: 30 cycles of grant 10 with tone, then idle.
    bus.click_req = 1; @(negedge clk); bus.click_req = 0;
    check("click_m0_grant", bus.grant, 0);
    for (int m = 1; m <= 32; m++) begin
      @(negedge clk);
      check($sformatf("click_grant@%0d", m), bus.grant, (m <= 30) ? 2 : 0);
      check($sformatf("click_beep@%0d", m), bus.beep, (m <= 30) ? tone_at(m - 1) : 0);
    end

    // Full alarm: ON/OFF/ON/OFF, single done pulse with grant release.
    bus.alarm_req = 1; @(negedge clk); bus.alarm_req = 0;
    for (int m = 1; m <= 85; m++) begin
      @(negedge clk);
      check($sformatf("alarm_grant@%0d", m), bus.grant, (m <= 80) ? 3 : 0);
      check($sformatf("alarm_beep@%0d", m), bus.beep, alarm_beep(m));
      check($sformatf("alarm_done@%0d", m), bus.alarm_done, (m == 81) ? 1 : 0);
    end

    // Preemption of melody by alarm, then melody resumes.
    bus.melody_en = 1; bus.melody_wave = 0;
    repeat (3) @(negedge clk);
    check("pre_melody_grant", bus.grant, 1);
    bus.alarm_req = 1; @(negedge clk); bus.alarm_req = 0;
    check("pre_m0_grant", bus.grant, 1);
    for (int m = 1; m <= 81; m++) begin
      @(negedge clk);
      check($sformatf("pre_grant@%0d", m), bus.grant, (m <= 80) ? 3 : 1);
      check($sformatf("pre_done@%0d", m), bus.alarm_done, (m == 81) ? 1 : 0);
    end
    pat = 8'b1011_0010;
    for (int i = 0; i < 8; i++) begin
      bus.melody_wave = pat[i];
      @(negedge clk);
      check($sformatf("pre_wave%0d", i), bus.beep, pat[i]);
    end
    bus.melody_en = 0; bus.melody_wave = 0;
    repeat (3) @(negedge clk);
    check("pre_idle_grant", bus.grant, 0);

    // Click dropped during ALARM_ON; then req+cancel together cancels.
    bus.alarm_req = 1; @(negedge clk); bus.alarm_req = 0;
    for (int m = 1; m <= 10; m++) begin
      bus.click_req = (m == 4);
      @(negedge clk);
      check($sformatf("drop_grant@%0d", m), bus.grant, 3);
      check($sformatf("drop_beep@%0d", m), bus.beep, alarm_beep(m));
    end
    bus.click_req = 0;
    bus.alarm_req = 1; bus.alarm_cancel = 1; @(negedge clk);
    bus.alarm_req = 0; bus.alarm_cancel = 0;
    check("cancel_m11_grant", bus.grant, 3);
    @(negedge clk);
    check("cancel_grant", bus.grant, 0);
    check("cancel_busy", bus.busy, 0);
    seen_done = 1'b0;
    for (int m = 0; m < 90; m++) begin
      @(negedge clk);
      if (bus.alarm_done !== 1'b0 || bus.grant !== 2'b00) seen_done = 1'b1;
    end
    check("cancel_no_done_or_owner", seen_done, 0);

    // Click restarted 15 cycles in: 45 cycles total.
    bus.click_req = 1; @(negedge clk); bus.click_req = 0;
    for (int m = 1; m <= 50; m++) begin
      bus.click_req = (m == 15);
      @(negedge clk);
      check($sformatf("rclick_grant@%0d", m), bus.grant, (m <= 45) ? 2 : 0);
      check($sformatf("rclick_beep@%0d", m), bus.beep,
            (m <= 15) ? tone_at(m - 1) : ((m <= 45) ? tone_at(m - 16) : 0));
    end
    bus.click_req = 0;

    // Alarm retriggered during the second OFF phase: full sequence restarts.
    bus.alarm_req = 1; @(negedge clk); bus.alarm_req = 0;
    for (int m = 1; m <= 150; m++) begin
      bus.alarm_req = (m == 65);
      @(negedge clk);
      check($sformatf("retrig_grant@%0d", m), bus.grant, (m <= 145) ? 3 : 0);
      check($sformatf("retrig_done@%0d", m), bus.alarm_done, (m == 146) ? 1 : 0);
      check($sformatf("retrig_beep@%0d", m), bus.beep,
            (m <= 65) ? alarm_beep(m) : alarm_beep(m - 65));
    end
    bus.alarm_req = 0;

    // Async reset during ALARM_ON clears outputs at once; IDLE afterwards.
    bus.alarm_req = 1; @(negedge clk); bus.alarm_req = 0;
    repeat (8) @(negedge clk);
    check("rstmid_beep_before", bus.beep, alarm_beep(8));
    check("rstmid_grant_before", bus.grant, 3);
    #2 rst = 1'b1;
    #1;
    check("rstmid_beep", bus.beep, 0);
    check("rstmid_grant", bus.grant, 0);
    check("rstmid_busy", bus.busy, 0);
    check("rstmid_done", bus.alarm_done, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int m = 1; m <= 20; m++) begin
      @(negedge clk);
      check($sformatf("post_rst_grant@%0d", m), bus.grant, 0);
      check($sformatf("post_rst_beep@%0d", m), bus.beep, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/buzzer_scheduler.md
# buzzer_scheduler

Owns the single `beep` pin and shares it between three requesters: the timer-expiry alarm, the key click, and the melody PWM path. It sits between the logic layer, the key module and the PWM/melody path on one side and the pin on the other, and replaces direct OR-ing of beep flags. Arbitration is fixed-priority with preemption. The block generates the alarm cadence and the click tone internally.

## Interface
- `TICK_DIV`, 50000: clock cycles per 1 ms tick; must be ≥1.
- `TONE_DIV`, 12500: half-period of the internal tone in cycles (2 kHz at 50 MHz); must be ≥1.
- `CLICK_MS`, 20: click duration in ms; must be ≥1.
- `ALARM_ON_MS`, 200: alarm on-phase in ms; must be ≥1.
- `ALARM_OFF_MS`, 200: alarm off-phase in ms; must be ≥1.
- `ALARM_REPEATS`, 5: on/off pairs per alarm; range 1..255.
- `CLK  in  1`: system clock, rising edge.
- `RSTn  in  1`: asynchronous reset, active-high; the port name follows codebase convention, the polarity does not.
- `alarm_req  in  1`: one-cycle pulse that starts or restarts the alarm.
- `alarm_cancel  in  1`: one-cycle pulse that aborts the alarm.
- `click_req  in  1`: one-cycle pulse that requests a key click.
- `melody_en  in  1`: level input (sing_flag); the melody owns the pin while it is high and nothing higher-priority is active.
- `melody_wave  in  1`: PWM waveform from the tone generator.
- `beep  out  1`: registered buzzer drive.
- `grant  out  2`: current owner; 00 none, 01 melody, 10 click, 11 alarm.
- `busy  out  1`: 1 whenever `grant` ≠ 00.
- `alarm_done  out  1`: one-cycle pulse when an alarm completes naturally.

## Operation
- Reset values: state IDLE; `beep`, `grant`, `busy` and `alarm_done` all 0; all counters 0.
- States are IDLE, MELODY, CLICK, ALARM_ON and ALARM_OFF. `grant` is a registered decode of the state.
- Priority order is alarm > click > melody. All inputs are sampled at the rising edge.
- `alarm_req` in any state → ALARM_ON at the next edge, with remaining = `ALARM_REPEATS`.
  - During an alarm, `alarm_req` retriggers the sequence from the start.
- `alarm_cancel` in ALARM_ON or ALARM_OFF → MELODY if `melody_en`=1, else IDLE. No `alarm_done` pulse is issued.
  - `alarm_cancel` outside an alarm is ignored.
  - `alarm_cancel` and `alarm_req` in the same cycle: cancel wins.
- Alarm sequence:
  - ALARM_ON lasts `ALARM_ON_MS` ms, then → ALARM_OFF.
  - ALARM_OFF lasts `ALARM_OFF_MS` ms. At its end, if remaining > 1: decrement remaining and → ALARM_ON. Otherwise → MELODY/IDLE (per `melody_en`) and pulse `alarm_done` for one cycle.
- `click_req` in IDLE or MELODY → CLICK for `CLICK_MS` ms, then → MELODY if `melody_en`=1, else IDLE.
  - `click_req` in CLICK restarts the duration.
  - `click_req` in an alarm state is dropped and is not queued.
- MELODY is entered from IDLE when `melody_en`=1, and left for IDLE when `melody_en`=0.
- `beep` source per state:
  - CLICK and ALARM_ON: internal tone.
  - MELODY: `melody_wave` delayed one register stage.
  - IDLE and ALARM_OFF: 0.
- Internal tone: toggles every `TONE_DIV` cycles. It is forced to 0 on every state entry, so the first rising edge occurs `TONE_DIV` cycles after entry.
- Interval timer: a prescaler plus ms counter, both cleared on every state entry, including retrigger/restart. A state lasting N ms therefore lasts exactly N·`TICK_DIV` cycles.
- Counter widths: prescaler uses $clog2(`TICK_DIV`); ms counter uses $clog2(max duration+1); remaining is 8 bits. No wrap-around is permitted within legal parameter ranges.

## Timing
- Request to state change: 1 cycle. A request at edge k gives `grant`/`busy` updated after edge k+1.
- `beep` is registered and follows state and tone with one cycle of latency.
- Timed-state exit: the state change is visible at the edge N·`TICK_DIV` cycles after the entry edge.
- `alarm_done` is asserted in the same cycle as the `grant` change out of ALARM_OFF.
- Async reset mid-operation: all outputs go to 0 immediately. After reset deasserts, IDLE holds until a new request arrives. Pending sequences are not resumed.

## Structure
- Package `buzzer_pkg` holds:
  - the state enum;
  - the `grant` encodings GNT_NONE, GNT_MELODY, GNT_CLICK and GNT_ALARM.
- Sub-module `ms_interval_timer` contains the prescaler, the ms counter, and a `clear` input. It outputs `ms_count` and `expired` against a loaded target.
- The top of the block holds the FSM, the tone toggler, the repeat counter and the output registers.

## Test plan
All scenarios use `TICK_DIV`=10, `TONE_DIV`=2, `CLICK_MS`=3, `ALARM_ON_MS`=2, `ALARM_OFF_MS`=2, `ALARM_REPEATS`=2.
- Click in IDLE: pulse `click_req` → `grant`=10 for exactly 30 cycles. `beep` toggles every 2 cycles starting 0 and is then 0. `grant`=00 afterwards.
- Full alarm: pulse `alarm_req` → 20 cycles ON, 20 OFF, 20 ON, 20 OFF. `alarm_done` is a single pulse at cycle 80. `beep`=0 throughout both OFF phases.
- Preemption: `melody_en`=1 with `grant`=01, then `alarm_req` → `grant`=11 next cycle. After `alarm_done`, `grant` returns to 01 and `beep` tracks `melody_wave` with a 1-cycle delay.
- Drop and cancel: `click_req` during ALARM_ON → ignored, `grant` stays 11. `alarm_req` and `alarm_cancel` in the same cycle → `grant`=00 next cycle, with no `alarm_done`.
- Restart: a second `click_req` 15 cycles into a click → CLICK lasts 45 cycles total. A retrigger `alarm_req` during the second OFF phase → the full 80-cycle sequence restarts.
- Reset mid-alarm: assert `RSTn`=1 during ALARM_ON → `beep`, `grant`, `busy` and `alarm_done` are 0 immediately. After release, state stays IDLE.
